// File: rtl/dma_reg_bank.sv
// DMA register bank and single-outstanding transfer sequencer on the register bus.
// Optional PERF_CYCLES counter at word 6 is built when DMA_REG_PERF_EN is defined.
module dma_reg_bank #(
    parameter int ALIGN_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_write,
    output logic [31:0] reg_rdata,
    output logic        xfer_valid,
    input  logic        xfer_ready,
    output logic [31:0] xfer_src,
    output logic [31:0] xfer_dst,
    output logic [31:0] xfer_len,
    input  logic        xfer_done,
    output logic        dma_en,
    output logic        intr
);

    localparam logic [31:0] AMASK =
        (ALIGN_BITS == 0) ? 32'hFFFF_FFFF : ~((32'd1 << ALIGN_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t      state, state_nxt;
    logic [31:0] src_base, dest_base, tail_ptr, head_ptr, dma_size;
    logic [31:0] lat_src, lat_dst, lat_len;
    logic        en_r, intr_r;
    logic        start, finish;
    logic        wr_src, wr_dst, wr_head, wr_size, wr_ctrl;

    assign wr_src  = reg_write && (reg_addr == 10'd0);
    assign wr_dst  = reg_write && (reg_addr == 10'd1);
    assign wr_head = reg_write && (reg_addr == 10'd3);
    assign wr_size = reg_write && (reg_addr == 10'd4);
    assign wr_ctrl = reg_write && (reg_addr == 10'd5);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en_r && (head_ptr != tail_ptr) && (dma_size != 32'd0)) begin
                    state_nxt = REQ;
                    start     = 1'b1;
                end
            end
            REQ: begin
                if (xfer_ready) state_nxt = BUSY;
            end
            BUSY: begin
                if (xfer_done) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_base  <= '0;
            dest_base <= '0;
            tail_ptr  <= '0;
            head_ptr  <= '0;
            dma_size  <= '0;
            lat_src   <= '0;
            lat_dst   <= '0;
            lat_len   <= '0;
            en_r      <= 1'b0;
            intr_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_src)  src_base  <= reg_wdata & AMASK;
            if (wr_dst)  dest_base <= reg_wdata & AMASK;
            if (wr_head) head_ptr  <= reg_wdata & AMASK;
            if (wr_size) dma_size  <= reg_wdata & AMASK;
            if (wr_ctrl) en_r      <= reg_wdata[0];
            if (start) begin
                lat_src <= src_base + tail_ptr;
                lat_dst <= dest_base + tail_ptr;
                lat_len <= dma_size;
            end
            if (finish) tail_ptr <= tail_ptr + lat_len;
            // completion sets INTR even when software clears it on the same edge
            if (finish) intr_r <= 1'b1;
            else if (wr_ctrl && reg_wdata[31]) intr_r <= 1'b0;
        end
    end

`ifdef DMA_REG_PERF_EN
    logic [31:0] perf_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (reg_write && (reg_addr == 10'd6)) begin
            perf_cycles <= '0;
        end else if ((state != IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            10'd0: reg_rdata = src_base;
            10'd1: reg_rdata = dest_base;
            10'd2: reg_rdata = tail_ptr;
            10'd3: reg_rdata = head_ptr;
            10'd4: reg_rdata = dma_size;
            10'd5: reg_rdata = {intr_r, 30'd0, en_r};
`ifdef DMA_REG_PERF_EN
            10'd6: reg_rdata = perf_cycles;
`endif
            default: reg_rdata = 32'd0;
        endcase
    end

    assign xfer_valid = (state == REQ);
    assign xfer_src   = lat_src;
    assign xfer_dst   = lat_dst;
    assign xfer_len   = lat_len;
    assign dma_en     = en_r;
    assign intr       = intr_r;

endmodule

// File: tb/tb_dma_reg_bank.sv
// Scoreboard bench for dma_reg_bank: expected transfers queued from register arithmetic.
module tb_dma_reg_bank;

    localparam int          AB = 2;
    localparam logic [31:0] AM = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write;
    logic [31:0] reg_rdata;
    logic        xfer_valid;
    logic        xfer_ready;
    logic [31:0] xfer_src, xfer_dst, xfer_len;
    logic        xfer_done;
    logic        dma_en;
    logic        intr;

    dma_reg_bank #(.ALIGN_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_write(reg_write), .reg_rdata(reg_rdata),
        .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
        .xfer_src(xfer_src), .xfer_dst(xfer_dst),
        .xfer_len(xfer_len), .xfer_done(xfer_done),
        .dma_en(dma_en), .intr(intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } xfer_t;

    xfer_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          auto_mode = 1'b0;
    bit          accepted = 1'b0;
    logic [31:0] m_src, m_dst, m_tail, m_head, m_size;
    logic        m_en, m_intr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compares accepted requests and checks held requests stay stable
    bit    pend = 1'b0;
    xfer_t held;
    always @(negedge clk) begin
        xfer_t e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("valid_held", {31'd0, xfer_valid}, 32'd1);
                chk("src_held", xfer_src, held.src);
                chk("dst_held", xfer_dst, held.dst);
                chk("len_held", xfer_len, held.len);
            end
            if (xfer_valid && xfer_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got src %h expected none", xfer_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_src", xfer_src, e.src);
                    chk("req_dst", xfer_dst, e.dst);
                    chk("req_len", xfer_len, e.len);
                end
                accepted = 1'b1;
                pend = 1'b0;
            end else if (xfer_valid) begin
                pend = 1'b1;
                held = '{xfer_src, xfer_dst, xfer_len};
            end else begin
                pend = 1'b0;
            end
        end
    end

    // engine model used in auto mode: random ready, random done latency
    initial begin
        int cnt;
        bit busy;
        cnt = 0;
        busy = 1'b0;
        xfer_ready = 1'b0;
        xfer_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_mode) begin
                xfer_done = 1'b0;
                if (accepted) begin
                    accepted = 1'b0;
                    busy = 1'b1;
                    xfer_ready = 1'b0;
                    cnt = $urandom_range(0, 4);
                end
                if (busy) begin
                    if (cnt == 0) begin
                        xfer_done = 1'b1;
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else begin
                    xfer_ready = ($urandom_range(0, 2) == 0);
                end
            end else begin
                busy = 1'b0;
                accepted = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        reg_addr = a;
        reg_wdata = d;
        reg_write = 1'b1;
        case (a)
            10'd0: m_src = d & AM;
            10'd1: m_dst = d & AM;
            10'd3: m_head = d & AM;
            10'd4: m_size = d & AM;
            10'd5: begin
                m_en = d[0];
                if (d[31]) m_intr = 1'b0;
            end
            default: ;
        endcase
        tick();
        reg_write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [9:0] a,
                          input logic [31:0] exp);
        reg_addr = a;
        #1;
        chk(name, reg_rdata, exp);
    endtask

    task automatic check_regs;
        rd_chk("rd_src", 10'd0, m_src);
        rd_chk("rd_dst", 10'd1, m_dst);
        rd_chk("rd_tail", 10'd2, m_tail);
        rd_chk("rd_head", 10'd3, m_head);
        rd_chk("rd_size", 10'd4, m_size);
        rd_chk("rd_ctrl", 10'd5, {m_intr, 30'd0, m_en});
`ifndef DMA_REG_PERF_EN
        rd_chk("rd_w6", 10'd6, 32'd0);
`endif
        chk("intr_pin", {31'd0, intr}, {31'd0, m_intr});
        chk("en_pin", {31'd0, dma_en}, {31'd0, m_en});
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] l);
        exp_q.push_back('{s, d, l});
    endtask

    task automatic do_reset;
        auto_mode = 1'b0;
        rst = 1'b1;
        reg_write = 1'b0;
        reg_addr = '0;
        reg_wdata = '0;
        xfer_ready = 1'b0;
        xfer_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        m_src = 0; m_dst = 0; m_tail = 0; m_head = 0; m_size = 0;
        m_en = 0; m_intr = 0;
    endtask

    task automatic wait_tail(input logic [31:0] exp, input int budget);
        reg_addr = 10'd2;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (reg_rdata == exp) break;
            tick();
            reg_addr = 10'd2;
        end
        chk("tail_reach", reg_rdata, exp);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (xfer_valid) break;
            tick();
        end
        chk("valid_up", {31'd0, xfer_valid}, 32'd1);
    endtask

    task automatic no_valid(input string name, input int n);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (xfer_valid) saw = 1'b1;
        end
        chk(name, {31'd0, saw}, 32'd0);
    endtask

    task automatic manual;
        auto_mode = 1'b0;
        xfer_ready = 1'b0;
        xfer_done = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] s, d, sz, hd;
        int k;

        do_reset();
        check_regs();
        chk("rst_valid", {31'd0, xfer_valid}, 32'd0);

        // alignment masking and ignored writes
        wr(10'd0, 32'h0000_1003);
        wr(10'd2, 32'h0000_0055);
        wr(10'd1, 32'h0000_ABCD);
        wr(10'd7, 32'hFFFF_FFFF);
        wr(10'd5, 32'h7FFF_FFFE);
        rd_chk("src_align", 10'd0, 32'h0000_1000);
        rd_chk("tail_ro", 10'd2, 32'h0);
        rd_chk("unmapped", 10'd7, 32'h0);
        check_regs();

        // two back-to-back transfers, first one held off by ready
        do_reset();
        wr(10'd0, 32'h1000);
        wr(10'd1, 32'h2000);
        wr(10'd4, 32'h100);
        wr(10'd3, 32'h200);
        push(32'h1000, 32'h2000, 32'h100);
        push(32'h1100, 32'h2100, 32'h100);
        wr(10'd5, 32'h1);
        wait_valid(10);
        repeat (5) tick();
        chk("hold_valid", {31'd0, xfer_valid}, 32'd1);
        chk("hold_src", xfer_src, 32'h1000);
        chk("hold_dst", xfer_dst, 32'h2000);
        chk("hold_len", xfer_len, 32'h100);
        auto_mode = 1'b1;
        wait_tail(32'h100, 200);
        chk("intr_first", {31'd0, intr}, 32'd1);
        wait_tail(32'h200, 200);
        m_tail = 32'h200;
        m_intr = 1'b1;
        no_valid("no_third", 8);
        chk("q_empty1", exp_q.size(), 0);
        manual();
        check_regs();

        // done together with W1C: set wins
        wr(10'd3, 32'h300);
        push(32'h1200, 32'h2200, 32'h100);
        wait_valid(10);
        xfer_ready = 1'b1;
        tick();
        xfer_ready = 1'b0;
        xfer_done = 1'b1;
        wr(10'd5, 32'h8000_0000);
        xfer_done = 1'b0;
        m_intr = 1'b1;
        m_tail = 32'h300;
        check_regs();
        wr(10'd5, 32'h8000_0001);
        check_regs();
        no_valid("idle_eq", 5);

        // done together with HEAD write: both apply
        wr(10'd3, 32'h400);
        push(32'h1300, 32'h2300, 32'h100);
        wait_valid(10);
        xfer_ready = 1'b1;
        tick();
        xfer_ready = 1'b0;
        xfer_done = 1'b1;
        wr(10'd3, 32'h501);
        xfer_done = 1'b0;
        m_tail = 32'h400;
        m_intr = 1'b1;
        rd_chk("head_both", 10'd3, 32'h500);
        rd_chk("tail_both", 10'd2, 32'h400);
        push(32'h1400, 32'h2400, 32'h100);
        auto_mode = 1'b1;
        wait_tail(32'h500, 200);
        m_tail = 32'h500;
        chk("q_empty2", exp_q.size(), 0);
        manual();

        // reset while a request is pending
        wr(10'd3, 32'h600);
        wait_valid(10);
        do_reset();
        chk("rst_req_valid", {31'd0, xfer_valid}, 32'd0);
        check_regs();

        // tail wrap past 2^32
        auto_mode = 1'b1;
        s = $urandom & AM;
        d = $urandom & AM;
        wr(10'd0, s);
        wr(10'd1, d);
        wr(10'd4, 32'hFFFF_FF00);
        wr(10'd3, 32'hFFFF_FF00);
        push(s, d, 32'hFFFF_FF00);
        wr(10'd5, 32'h1);
        wait_tail(32'hFFFF_FF00, 200);
        wr(10'd4, 32'h200);
        push(s + 32'hFFFF_FF00, d + 32'hFFFF_FF00, 32'h200);
        wr(10'd3, 32'h100);
        wait_tail(32'h100, 200);
        m_tail = 32'h100;
        m_intr = 1'b1;
        manual();

        // EN cleared while BUSY: transfer finishes, nothing new issued
        wr(10'd3, 32'h500);
        push(s + 32'h100, d + 32'h100, 32'h200);
        wait_valid(10);
        xfer_ready = 1'b1;
        tick();
        xfer_ready = 1'b0;
        wr(10'd5, 32'h0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        m_tail = 32'h300;
        rd_chk("tail_en_off", 10'd2, 32'h300);
        no_valid("no_req_en_off", 10);
        check_regs();
        chk("q_empty3", exp_q.size(), 0);

        // randomized rounds
        auto_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            wr(10'd5, 32'h8000_0000);
            s = $urandom;
            d = $urandom;
            sz = (r % 2 == 1) ? $urandom : ($urandom_range(1, 64) << 2);
            sz = sz | 32'h4;
            if ((sz & AM) == 32'h8000_0000) sz = 32'h0000_0104;
            wr(10'd0, s);
            wr(10'd1, d);
            wr(10'd4, sz);
            k = $urandom_range(1, 3);
            hd = m_tail + m_size * k;
            for (int j = 0; j < k; j++)
                push(m_src + m_tail + m_size * j,
                     m_dst + m_tail + m_size * j, m_size);
            wr(10'd3, hd | 32'($urandom_range(0, 3)));
            wr(10'd5, 32'h1 | ($urandom & 32'h7FFF_FFFE));
            wait_tail(hd, 600);
            m_tail = hd;
            m_intr = 1'b1;
            tick();
            chk("q_empty_rnd", exp_q.size(), 0);
            check_regs();
        end
        manual();

`ifdef DMA_REG_PERF_EN
        do_reset();
        wr(10'd4, 32'h40);
        wr(10'd3, 32'h40);
        push(32'h0, 32'h0, 32'h40);
        wr(10'd5, 32'h1);
        wait_valid(10);
        repeat (3) tick();
        xfer_ready = 1'b1;
        tick();
        xfer_ready = 1'b0;
        repeat (3) tick();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        rd_chk("perf_cnt", 10'd6, 32'd8);
        wr(10'd6, 32'h1234);
        rd_chk("perf_clr", 10'd6, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_reg_bank.md
Name: dma_reg_bank

Overview:
- Register bank and transfer sequencer behind the AXI4-Lite-to-register-bus bridge of the custom CPU's DMA path.
- Decodes the simple register bus: 10-bit word address, write strobe, 32-bit data.
- Holds the DMA configuration and ring pointers.
- Issues one sub-buffer transfer request at a time to the DMA engine over a valid/ready handshake, and tracks completion and the interrupt.

Parameters:
ALIGN_BITS, 2, number of LSBs forced to zero on writes to SRC_BASE, DEST_BASE, HEAD_PTR, DMA_SIZE (0 = no forcing).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
reg_addr  input  10  word index of register
reg_wdata  input  32  write data (already strobe-masked upstream)
reg_write  input  1  single-cycle write strobe
reg_rdata  output  32  read data, combinational from reg_addr
xfer_valid  output  1  transfer request valid
xfer_ready  input  1  engine accepts request
xfer_src  output  32  source address = SRC_BASE + TAIL_PTR
xfer_dst  output  32  destination address = DEST_BASE + TAIL_PTR
xfer_len  output  32  byte length = DMA_SIZE
xfer_done  input  1  single-cycle pulse: accepted transfer finished
dma_en  output  1  CTRL.EN
intr  output  1  CTRL.INTR

Behaviour:
Register map (word index):
- 0 SRC_BASE: RW
- 1 DEST_BASE: RW
- 2 TAIL_PTR: RO, writes ignored
- 3 HEAD_PTR: RW
- 4 DMA_SIZE: RW
- 5 CTRL: bit0 EN RW; bit31 INTR, write-1-to-clear; other bits read 0, writes ignored
- 6..1023: read 0, writes ignored

Bus timing:
- Writes take effect on the clk edge where reg_write=1.
- reg_rdata is purely combinational from reg_addr and current register state, with zero latency; it reflects a write from the following cycle onward.

Reset:
- All registers 0; FSM in IDLE.
- xfer_valid=0, dma_en=0, intr=0, reg_rdata reflects the zeroed registers.

FSM states: IDLE, REQ, BUSY.
- IDLE -> REQ when EN=1, HEAD_PTR != TAIL_PTR and DMA_SIZE != 0.
  - On that edge, latch src = SRC_BASE+TAIL_PTR, dst = DEST_BASE+TAIL_PTR, len = DMA_SIZE.
  - All additions are 32-bit modulo 2^32.
- REQ: xfer_valid=1; xfer_src/dst/len are driven from the latched values and held stable until accepted.
  - REQ -> BUSY on xfer_valid && xfer_ready.
- BUSY: xfer_valid=0.
  - On xfer_done: TAIL_PTR <= TAIL_PTR + latched len (wraps mod 2^32), INTR <= 1, go to IDLE.
- Handshake rule: once raised, xfer_valid is never withdrawn before acceptance, even if EN is cleared or HEAD_PTR is rewritten.
- xfer_done outside BUSY is ignored.
- Outside REQ, xfer_src/dst/len show the last latched values.

Boundary conditions:
- EN cleared during REQ/BUSY: the current transfer completes normally; no new request is issued.
- DMA_SIZE or base rewritten during REQ/BUSY: has no effect on the in-flight transfer; TAIL_PTR advances by the latched len.
- xfer_done and a CTRL write with bit31=1 in the same cycle: the set wins, INTR=1.
- xfer_done and a HEAD_PTR write in the same cycle: both updates apply.
- IDLE re-evaluates its entry condition on the cycle after returning, so back-to-back transfers have a 1-cycle IDLE gap.
- Masking by ALIGN_BITS applies to written values only; TAIL_PTR is never masked.
- rst asserted in REQ or BUSY: immediate return to the reset state; a pending xfer_done is dropped.

Optional Feature:
Macro DMA_REG_PERF_EN.
- Defined:
  - Word 6 becomes PERF_CYCLES, a 32-bit counter of cycles spent in REQ or BUSY, saturating at 0xFFFFFFFF.
  - Any write to word 6 clears it to 0; if the FSM is in REQ/BUSY that cycle, the counter is 0 after the edge.
  - Reset value 0.
- Undefined: no counter logic; word 6 reads 0 like other unmapped words.

Test Plan:
- Reset then read indices 0-6 -> all return 0x00000000; xfer_valid=0, intr=0.
- Write SRC_BASE=0x1003 (ALIGN_BITS=2) and TAIL_PTR=0x55 -> SRC_BASE reads 0x1000; TAIL_PTR reads 0.
- SRC=0x1000, DEST=0x2000, SIZE=0x100, HEAD=0x200, EN=1; xfer_ready held low 5 cycles -> xfer_valid stays 1 with src 0x1000, dst 0x2000, len 0x100.
  - Then ready=1, done pulse -> TAIL=0x100, intr=1.
  - Second request (src 0x1100) issues automatically; after its done, TAIL=0x200 and no third request.
- Write CTRL=0x80000000 in the same cycle as xfer_done -> intr remains 1.
  - Next CTRL=0x80000001 write with no done -> intr=0, EN=1.
- TAIL at 0xFFFFFF00, SIZE=0x200 -> after done, TAIL=0x00000100.
  - Clearing EN while in BUSY -> done still accepted and TAIL advances; no new xfer_valid.
- With DMA_REG_PERF_EN: ready delayed 3 cycles, done 4 cycles after acceptance -> PERF_CYCLES reads 8.
  - A write to word 6 -> reads 0.
